// File: rtl/uart_cmd_parser_pkg.sv
// rtl/uart_cmd_parser_pkg.sv - shared command codes, response bytes and state encoding for uart_cmd_parser
package uart_cmd_parser_pkg;

  localparam logic [7:0] CMD_WRITE         = 8'h01;
  localparam logic [7:0] CMD_READ          = 8'h02;
  localparam logic [7:0] ACK_BYTE          = 8'h06;
  localparam logic [7:0] NAK_BYTE          = 8'h15;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_AH,
    ST_AL,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_COMMIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_TX_SEND,
    ST_TX_WAIT
  } state_t;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - memory bus and transmitter handshake bundle of uart_cmd_parser
interface uart_cmd_parser_if;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re, tx_start, tx_data,
    input  mem_rdata, mem_rvalid, tx_busy
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re, tx_start, tx_data,
    output mem_rdata, mem_rvalid, tx_busy
  );

endinterface

// File: rtl/uart_cmd_buf.sv
// rtl/uart_cmd_buf.sv - MAX_LEN x 8 payload buffer, synchronous write, index-addressed combinational read
module uart_cmd_buf #(
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - packet parser: checksummed writes to memory, reads streamed to the transmitter
// Optional inter-byte timeout enabled by UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 12000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_rcv,
  input  logic [7:0]             rx_data,
  uart_cmd_parser_if.master      bus,
  output logic                   busy,
  output logic                   err
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_cmd_parser: MAX_LEN or TIMEOUT_CYCLES out of range");
  end

  state_t      state, state_n;
  logic        is_wr, is_wr_n;
  logic [15:0] addr, addr_n;
  logic [7:0]  len, len_n;
  logic [7:0]  idx, idx_n;
  logic [7:0]  csum, csum_n;
  logic [7:0]  rsp, rsp_n;
  logic [7:0]  txd, txd_n;
  logic        last, last_n;
  logic        err_q, err_n;
  logic        buf_we;
  logic [7:0]  buf_rdata;
  logic        tmo_hit;

`ifdef UART_CMD_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        rx_phase;

  assign rx_phase = state inside {ST_CMD, ST_AH, ST_AL, ST_LEN, ST_PAYLOAD, ST_CSUM};
  assign tmo_hit  = rx_phase && !rx_rcv && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     tmo_cnt <= '0;
    else if (!rx_phase || rx_rcv) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + 32'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  uart_cmd_buf #(.MAX_LEN(MAX_LEN), .IDX_W(IDX_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (idx[IDX_W-1:0]),
    .wdata (rx_data),
    .raddr (idx[IDX_W-1:0]),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      is_wr <= 1'b0;
      addr  <= '0;
      len   <= '0;
      idx   <= '0;
      csum  <= '0;
      rsp   <= '0;
      txd   <= '0;
      last  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      is_wr <= is_wr_n;
      addr  <= addr_n;
      len   <= len_n;
      idx   <= idx_n;
      csum  <= csum_n;
      rsp   <= rsp_n;
      txd   <= txd_n;
      last  <= last_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    is_wr_n = is_wr;
    addr_n  = addr;
    len_n   = len;
    idx_n   = idx;
    csum_n  = csum;
    rsp_n   = rsp;
    txd_n   = txd;
    last_n  = last;
    err_n   = 1'b0;
    buf_we  = 1'b0;
    case (state)
      ST_IDLE: if (rx_rcv && rx_data == SYNC_BYTE) state_n = ST_CMD;
      ST_CMD: if (rx_rcv) begin
        if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
          is_wr_n = (rx_data == CMD_WRITE);
          csum_n  = rx_data;
          state_n = ST_AH;
        end else begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_AH: if (rx_rcv) begin
        addr_n[15:8] = rx_data;
        csum_n       = csum ^ rx_data;
        state_n      = ST_AL;
      end
      ST_AL: if (rx_rcv) begin
        addr_n[7:0] = rx_data;
        csum_n      = csum ^ rx_data;
        state_n     = ST_LEN;
      end
      ST_LEN: if (rx_rcv) begin
        if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          len_n   = rx_data;
          idx_n   = '0;
          csum_n  = csum ^ rx_data;
          state_n = is_wr ? ST_PAYLOAD : ST_CSUM;
        end
      end
      ST_PAYLOAD: if (rx_rcv) begin
        buf_we = 1'b1;
        csum_n = csum ^ rx_data;
        idx_n  = idx + 8'd1;
        if (idx + 8'd1 == len) state_n = ST_CSUM;
      end
      ST_CSUM: if (rx_rcv) begin
        idx_n = '0;
        rsp_n = '0;
        if (rx_data != csum) begin
          err_n   = 1'b1;
          txd_n   = NAK_BYTE;
          last_n  = 1'b1;
          state_n = ST_TX_SEND;
        end else begin
          state_n = is_wr ? ST_COMMIT : ST_RD_REQ;
        end
      end
      ST_COMMIT: begin
        addr_n = addr + 16'd1;
        idx_n  = idx + 8'd1;
        if (idx + 8'd1 == len) begin
          txd_n   = ACK_BYTE;
          last_n  = 1'b1;
          state_n = ST_TX_SEND;
        end
      end
      ST_RD_REQ: state_n = ST_RD_WAIT;
      ST_RD_WAIT: if (bus.mem_rvalid) begin
        txd_n   = bus.mem_rdata;
        rsp_n   = rsp ^ bus.mem_rdata;
        addr_n  = addr + 16'd1;
        idx_n   = idx + 8'd1;
        last_n  = 1'b0;
        state_n = ST_TX_SEND;
      end
      ST_TX_SEND: if (bus.tx_busy) state_n = ST_TX_WAIT;
      ST_TX_WAIT: if (!bus.tx_busy) begin
        // After the last read data byte the accumulated XOR goes out as the trailer.
        if (last) begin
          state_n = ST_IDLE;
        end else if (idx == len) begin
          txd_n   = rsp;
          last_n  = 1'b1;
          state_n = ST_TX_SEND;
        end else begin
          state_n = ST_RD_REQ;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (rx_rcv && state inside {ST_COMMIT, ST_RD_REQ, ST_RD_WAIT, ST_TX_SEND, ST_TX_WAIT})
      err_n = 1'b1;
    if (tmo_hit) begin
      err_n   = 1'b1;
      state_n = ST_IDLE;
    end
  end

  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = buf_rdata;
  assign bus.mem_we    = (state == ST_COMMIT);
  assign bus.mem_re    = (state == ST_RD_REQ);
  assign bus.tx_start  = (state == ST_TX_SEND);
  assign bus.tx_data   = txd;
  assign busy          = (state != ST_IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - scoreboard bench for uart_cmd_parser with memory and transmitter models
module tb_uart_cmd_parser;

  localparam int MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_rcv;
  logic [7:0] rx_data;
  logic       busy;
  logic       err;

  uart_cmd_parser_if ifc ();

  uart_cmd_parser #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_rcv  (rx_rcv),
    .rx_data (rx_data),
    .bus     (ifc.master),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int err_base = 0;
  int stall_cfg = 0;

  logic [23:0] we_q[$];
  logic [23:0] rd_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  pkt[$];
  logic [7:0]  pay[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: checks reads/writes against the scoreboard, answers reads 3 cycles later.
  initial begin
    int rd_cnt = 0;
    logic [7:0] rd_val = 8'h00;
    logic [23:0] e;
    ifc.mem_rvalid = 1'b0;
    ifc.mem_rdata  = 8'hEE;
    forever begin
      @(negedge clk);
      ifc.mem_rvalid = 1'b0;
      ifc.mem_rdata  = 8'hEE;
      if (err) err_cnt++;
      if (rst) begin
        rd_cnt = 0;
      end else begin
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            ifc.mem_rvalid = 1'b1;
            ifc.mem_rdata  = rd_val;
          end
        end
        if (ifc.mem_we) begin
          if (we_q.size() == 0) check("we_unexpected", 1, 0);
          else begin
            e = we_q.pop_front();
            check("we_addr", ifc.mem_addr, e[23:8]);
            check("we_data", ifc.mem_wdata, e[7:0]);
          end
        end
        if (ifc.mem_re) begin
          if (rd_q.size() == 0) check("re_unexpected", 1, 0);
          else begin
            e = rd_q.pop_front();
            check("re_addr", ifc.mem_addr, e[23:8]);
            rd_val = e[7:0];
            rd_cnt = 3;
          end
        end
      end
    end
  end

  // Transmitter model: optional stall before accepting, then busy for a few cycles.
  initial begin
    int busy_left = 0;
    int stall_left = 0;
    bit seen = 0;
    logic [7:0] hold = 8'h00;
    logic [7:0] e;
    ifc.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ifc.tx_busy = 1'b0;
        busy_left = 0;
        seen = 0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) ifc.tx_busy = 1'b0;
      end else if (ifc.tx_start) begin
        if (!seen) begin
          seen = 1;
          hold = ifc.tx_data;
          stall_left = stall_cfg;
        end else begin
          check("tx_hold", ifc.tx_data, hold);
        end
        if (stall_left > 0) stall_left--;
        else begin
          if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
          else begin
            e = tx_q.pop_front();
            check("tx_byte", ifc.tx_data, e);
          end
          ifc.tx_busy = 1'b1;
          busy_left = 3;
          seen = 0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_rcv  = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_rcv  = 1'b0;
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send_byte(pkt[i]);
  endtask

  task automatic mk_write(input logic [15:0] a);
    logic [7:0] cs;
    cs = 8'h01 ^ a[15:8] ^ a[7:0] ^ 8'(pay.size());
    pkt = {8'hA5, 8'h01, a[15:8], a[7:0], 8'(pay.size())};
    foreach (pay[i]) begin
      cs ^= pay[i];
      pkt.push_back(pay[i]);
      we_q.push_back({16'(a + 16'(i)), pay[i]});
    end
    pkt.push_back(cs);
    tx_q.push_back(8'h06);
  endtask

  task automatic mk_read(input logic [15:0] a);
    logic [7:0] x;
    x = 8'h00;
    pkt = {8'hA5, 8'h02, a[15:8], a[7:0], 8'(pay.size()),
           8'h02 ^ a[15:8] ^ a[7:0] ^ 8'(pay.size())};
    foreach (pay[i]) begin
      rd_q.push_back({16'(a + 16'(i)), pay[i]});
      tx_q.push_back(pay[i]);
      x ^= pay[i];
    end
    tx_q.push_back(x);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 3000);
    check("idle", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_done(input string tag, input int errs);
    check({tag, "_err"}, err_cnt - err_base, errs);
    check({tag, "_we_left"}, we_q.size(), 0);
    check({tag, "_re_left"}, rd_q.size(), 0);
    check({tag, "_tx_left"}, tx_q.size(), 0);
    err_base = err_cnt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rx_rcv = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_we", ifc.mem_we, 0);
    check("rst_re", ifc.mem_re, 0);
    check("rst_tx_start", ifc.tx_start, 0);
    check("rst_tx_data", ifc.tx_data, 0);
    check("rst_addr", ifc.mem_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    pay = {8'hAA, 8'hBB};
    mk_write(16'h1234);
    send_pkt();
    wait_idle();
    expect_done("write", 0);

    pkt = {8'hA5, 8'h01, 8'h00, 8'h10, 8'h01, 8'h55, 8'h00};
    tx_q.push_back(8'h15);
    send_pkt();
    wait_idle();
    expect_done("bad_csum", 1);

    pay = {8'h11, 8'h22};
    mk_read(16'hFFFF);
    send_pkt();
    wait_idle();
    expect_done("read_wrap", 0);

    pkt = {8'hA5, 8'h07};
    send_pkt();
    wait_idle();
    expect_done("bad_cmd", 1);
    pkt = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00};
    send_pkt();
    wait_idle();
    expect_done("len_zero", 1);
    pkt = {8'hA5, 8'h01, 8'h00, 8'h00, 8'(MAX_LEN + 1)};
    send_pkt();
    wait_idle();
    expect_done("len_over", 1);

    pay = {};
    for (int i = 0; i < MAX_LEN; i++) pay.push_back(8'(i * 7 + 3));
    mk_write(16'hFFF8);
    send_pkt();
    wait_idle();
    expect_done("write_max", 0);

    pay = {8'h5C};
    mk_write(16'h0200);
    pkt = {8'h00, 8'hFF, 8'h5A, pkt};
    send_pkt();
    wait_idle();
    expect_done("sync_hunt", 0);

    pkt = {8'hA5, 8'h01, 8'h00, 8'h20, 8'h03, 8'hAA, 8'hBB};
    send_pkt();
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_we", ifc.mem_we, 0);
    check("midrst_tx_start", ifc.tx_start, 0);
    check("midrst_addr", ifc.mem_addr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    expect_done("mid_reset", 0);

    stall_cfg = 100;
    pay = {8'h9E};
    mk_write(16'h0050);
    send_pkt();
    repeat (20) @(negedge clk);
    check("stall_start", ifc.tx_start, 1);
    send_byte(8'h33);
    wait_idle();
    stall_cfg = 0;
    expect_done("tx_stall", 1);

`ifdef UART_CMD_TIMEOUT_EN
    pkt = {8'hA5, 8'h01};
    send_pkt();
    repeat (60) @(negedge clk);
    check("tmo_busy", busy, 0);
    expect_done("timeout", 1);
`else
    pay = {8'h77};
    mk_write(16'h0040);
    send_byte(pkt[0]);
    send_byte(pkt[1]);
    repeat (1000) @(negedge clk);
    check("no_tmo_busy", busy, 1);
    for (int i = 2; i < pkt.size(); i++) send_byte(pkt[i]);
    wait_idle();
    expect_done("no_timeout", 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
